// File: rtl/tx_interleaver.sv
// 802.11a transmit block interleaver: serial coded bits in, 48 subcarrier groups of
// N_BPSC bits out per OFDM symbol, with two ping-pong banks so one fills while one drains.
module tx_interleaver (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_mod,
   input  logic       i_in_bit,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic [5:0] o_out_bits,
   output logic       o_out_valid,
   input  logic       i_out_ready
);

   localparam logic [1:0] MOD_BPSK  = 2'd0;
   localparam logic [1:0] MOD_QPSK  = 2'd1;
   localparam logic [1:0] MOD_16QAM = 2'd2;
   localparam logic [1:0] MOD_64QAM = 2'd3;

   function automatic logic [4:0] f_ncol(input logic [1:0] mod);
      case (mod)
         MOD_BPSK:  f_ncol = 5'd3;
         MOD_QPSK:  f_ncol = 5'd6;
         MOD_16QAM: f_ncol = 5'd12;
         MOD_64QAM: f_ncol = 5'd18;
         default:   f_ncol = 5'd3;
      endcase
   endfunction

   function automatic logic [2:0] f_nbpsc(input logic [1:0] mod);
      case (mod)
         MOD_BPSK:  f_nbpsc = 3'd1;
         MOD_QPSK:  f_nbpsc = 3'd2;
         MOD_16QAM: f_nbpsc = 3'd4;
         MOD_64QAM: f_nbpsc = 3'd6;
         default:   f_nbpsc = 3'd1;
      endcase
   endfunction

   function automatic logic [1:0] f_mod3(input logic [3:0] v);
      case (v)
         4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: f_mod3 = 2'd0;
         4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       f_mod3 = 2'd1;
         default:                              f_mod3 = 2'd2;
      endcase
   endfunction

   // (a - b) mod 3 for a, b already reduced to 0..2
   function automatic logic [1:0] f_sub_mod3(input logic [1:0] a, input logic [1:0] b);
      if (a >= b) f_sub_mod3 = a - b;
      else        f_sub_mod3 = a + 2'd3 - b;
   endfunction

   logic [287:0] r_bank [2];
   logic [1:0]   r_bank_mod [2];
   logic [1:0]   r_full;
   logic         r_wbank;
   logic         r_rbank;
   logic [3:0]   r_r;
   logic [4:0]   r_q;
   logic [1:0]   r_q3;
   logic [5:0]   r_m;

   logic         w_in_acc;
   logic         w_out_acc;
   logic         w_first;
   logic         w_last;
   logic [1:0]   w_wmod;
   logic [4:0]   w_ncol;
   logic [8:0]   w_i;
   logic [8:0]   w_j;
   logic [1:0]   w_rmod;
   logic [2:0]   w_nbpsc;
   logic [8:0]   w_base;
   logic [5:0]   w_bits;
   logic [1:0]   w_full_nxt;

   assign o_in_ready  = ~r_full[r_wbank];
   assign w_in_acc    = i_in_valid & ~r_full[r_wbank];
   assign o_out_valid = r_full[r_rbank];
   assign w_out_acc   = r_full[r_rbank] & i_out_ready;
   assign o_out_bits  = w_bits;

   // Write address: first permutation, then the per-modulation bit rotation
   always_comb begin
      w_first = (r_r == 4'd0) && (r_q == 5'd0);
      if (w_first) w_wmod = i_mod;
      else         w_wmod = r_bank_mod[r_wbank];
      w_ncol = f_ncol(w_wmod);
      w_i    = {4'd0, w_ncol} * {5'd0, r_r} + {4'd0, r_q};
      case (w_wmod)
         MOD_16QAM: w_j = w_i - {8'd0, r_q[0]} + {8'd0, r_q[0] ^ r_r[0]};
         MOD_64QAM: w_j = w_i - {7'd0, r_q3} + {7'd0, f_sub_mod3(r_q3, f_mod3(r_r))};
         default:   w_j = w_i;
      endcase
      w_last = (r_r == 4'd15) && (r_q == (w_ncol - 5'd1));
   end

   // Read side: gather group m from the read bank using that bank's latched modulation
   always_comb begin
      w_rmod  = r_bank_mod[r_rbank];
      w_nbpsc = f_nbpsc(w_rmod);
      w_base  = {3'd0, r_m} * {6'd0, w_nbpsc};
      w_bits  = 6'd0;
      for (int b = 0; b < 6; b++) begin
         if (r_full[r_rbank] && (w_nbpsc > 3'(b))) w_bits[b] = r_bank[r_rbank][w_base + 9'(b)];
         else                                       w_bits[b] = 1'b0;
      end
   end

   // Full flags: writer completion and reader release may land on the same edge
   always_comb begin
      w_full_nxt = r_full;
      if (w_in_acc && w_last) w_full_nxt[r_wbank] = 1'b1;
      else                    w_full_nxt[r_wbank] = r_full[r_wbank];
      if (w_out_acc && (r_m == 6'd47)) w_full_nxt[r_rbank] = 1'b0;
      else                             w_full_nxt[r_rbank] = w_full_nxt[r_rbank];
   end

   // Bank storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bank[0] <= {288{1'b0}};
         r_bank[1] <= {288{1'b0}};
      end else if (w_in_acc) begin
         r_bank[r_wbank][w_j] <= i_in_bit;
      end
   end

   // Write counters, bank pointers, latched modulation and flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bank_mod[0] <= 2'd0;
         r_bank_mod[1] <= 2'd0;
         r_full        <= 2'b00;
         r_wbank       <= 1'b0;
         r_rbank       <= 1'b0;
         r_r           <= 4'd0;
         r_q           <= 5'd0;
         r_q3          <= 2'd0;
         r_m           <= 6'd0;
      end else begin
         r_full <= w_full_nxt;
         if (w_in_acc) begin
            if (w_first) r_bank_mod[r_wbank] <= i_mod;
            if (w_last) begin
               r_r     <= 4'd0;
               r_q     <= 5'd0;
               r_q3    <= 2'd0;
               r_wbank <= ~r_wbank;
            end else if (r_r == 4'd15) begin
               r_r  <= 4'd0;
               r_q  <= r_q + 5'd1;
               r_q3 <= (r_q3 == 2'd2) ? 2'd0 : r_q3 + 2'd1;
            end else begin
               r_r <= r_r + 4'd1;
            end
         end
         if (w_out_acc) begin
            if (r_m == 6'd47) begin
               r_m     <= 6'd0;
               r_rbank <= ~r_rbank;
            end else begin
               r_m <= r_m + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tx_interleaver.sv
// Self-checking bench for tx_interleaver: directed test-plan symbols plus random streams
// compared against a model built from the textbook 802.11a interleaver formulas.
module tb_tx_interleaver;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] i_mod;
   logic       i_in_bit;
   logic       i_in_valid;
   logic       i_out_ready;
   logic       o_in_ready;
   logic [5:0] o_out_bits;
   logic       o_out_valid;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [5:0] exp_q[$];
   int         n_full = 0;
   int         pops   = 0;
   int         mk     = 0;
   logic [1:0] m_mod  = 2'd0;
   logic       cur_bits [288];

   tx_interleaver dut (
      .clk        (clk),
      .rst        (rst),
      .i_mod      (i_mod),
      .i_in_bit   (i_in_bit),
      .i_in_valid (i_in_valid),
      .o_in_ready (o_in_ready),
      .o_out_bits (o_out_bits),
      .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int nbpsc_of(input logic [1:0] md);
      case (md)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 6;
      endcase
   endfunction

   // Permute the completed symbol with the standard two-step formula and queue its groups
   task automatic finish_symbol();
      int   nb    = nbpsc_of(m_mod);
      int   ncbps = 48 * nb;
      int   s     = (nb > 2) ? nb / 2 : 1;
      logic perm [288];
      for (int x = 0; x < 288; x++) perm[x] = 1'b0;
      for (int k = 0; k < ncbps; k++) begin
         int i = (ncbps / 16) * (k % 16) + k / 16;
         int j = s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
         perm[j] = cur_bits[k];
      end
      for (int m = 0; m < 48; m++) begin
         logic [5:0] g = 6'd0;
         for (int b = 0; b < nb; b++) g[b] = perm[m * nb + b];
         exp_q.push_back(g);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      n_full = 0;
      pops   = 0;
      mk     = 0;
   endtask

   // ordy: 0 = out_ready low, 1 = high, 2 = random; kone<0 gives random bits
   task automatic run(input int nbits, input logic [1:0] md, input int kone,
                      input int ordy, input bit drain);
      int   left = nbits;
      int   cyc  = 0;
      logic acc_in;
      logic acc_out;
      while ((left > 0 || (drain && n_full > 0)) && cyc < 4000) begin
         i_in_valid  = (left > 0);
         i_in_bit    = (kone < 0) ? 1'($urandom) : (mk == kone);
         i_mod       = (mk == 0) ? md : 2'($urandom);
         i_out_ready = (ordy == 2) ? 1'($urandom) : (ordy == 1);
         @(negedge clk);
         check("in_ready", 9'(o_in_ready), 9'(n_full < 2));
         check("out_valid", 9'(o_out_valid), 9'(n_full > 0));
         check("out_bits", 9'(o_out_bits), (n_full > 0) ? 9'(exp_q[0]) : 9'd0);
         acc_out = (n_full > 0) && i_out_ready;
         acc_in  = i_in_valid && (n_full < 2);
         if (acc_out) begin
            void'(exp_q.pop_front());
            pops++;
            if (pops == 48) begin
               pops = 0;
               n_full--;
            end
         end
         if (acc_in) begin
            if (mk == 0) m_mod = i_mod;
            cur_bits[mk] = i_in_bit;
            mk++;
            left--;
            if (mk == 48 * nbpsc_of(m_mod)) begin
               finish_symbol();
               mk = 0;
               n_full++;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      i_in_valid = 1'b0;
      check("run_budget", 9'(cyc < 4000), 9'd1);
   endtask

   // Drain the single stored symbol expecting one hot group at mhot
   task automatic drain_expect(input int mhot, input logic [5:0] val);
      i_in_valid  = 1'b0;
      i_out_ready = 1'b1;
      for (int m = 0; m < 48; m++) begin
         @(negedge clk);
         check("dir_valid", 9'(o_out_valid), 9'd1);
         check("dir_bits", 9'(o_out_bits), (m == mhot) ? 9'(val) : 9'd0);
         void'(exp_q.pop_front());
         @(posedge clk);
         #1;
      end
      n_full--;
      @(negedge clk);
      check("dir_done", 9'(o_out_valid), 9'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b0;
      i_mod       = 2'd0;
      i_in_bit    = 1'b0;
      i_in_valid  = 1'b0;
      i_out_ready = 1'b0;
      #1;
      check("rst_in_ready", 9'(o_in_ready), 9'd1);
      check("rst_out_valid", 9'(o_out_valid), 9'd0);
      check("rst_out_bits", 9'(o_out_bits), 9'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // directed single-bit symbols
      run(48, 2'd0, 1, 0, 1'b0);
      drain_expect(3, 6'b000001);
      run(96, 2'd1, 16, 0, 1'b0);
      drain_expect(0, 6'b000010);
      run(192, 2'd2, 17, 0, 1'b0);
      drain_expect(3, 6'b000001);
      run(288, 2'd3, 1, 0, 1'b0);
      drain_expect(3, 6'b000100);

      // both banks full: bit 97 stalls until the first symbol drains
      run(96, 2'd0, -1, 0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         i_in_valid  = 1'b1;
         i_in_bit    = 1'b1;
         i_out_ready = 1'b0;
         @(negedge clk);
         check("stall_in_ready", 9'(o_in_ready), 9'd0);
         check("stall_out_valid", 9'(o_out_valid), 9'd1);
         @(posedge clk);
         #1;
      end
      run(48, 2'd0, -1, 1, 1'b1);

      // back-to-back random symbols across modulations
      run(192, 2'd1, -1, 1, 1'b0);
      run(192, 2'd2, -1, 1, 1'b0);
      run(576, 2'd3, -1, 1, 1'b1);
      run(288, 2'd3, -1, 2, 1'b0);
      run(144, 2'd0, -1, 2, 1'b1);

      // reset in the middle of a QPSK symbol
      run(20, 2'd1, -1, 1, 1'b0);
      i_in_valid = 1'b0;
      rst = 1'b0;
      #2;
      check("mid_rst_in_ready", 9'(o_in_ready), 9'd1);
      check("mid_rst_out_valid", 9'(o_out_valid), 9'd0);
      check("mid_rst_out_bits", 9'(o_out_bits), 9'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run(48, 2'd0, -1, 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_interleaver.md
# tx_interleaver

Transmit-side 802.11a block interleaver sitting between the convolutional encoder/puncturer and the subcarrier mapper. Accepts coded bits serially, one per accepted cycle, applies the two-step 802.11a permutation for the current modulation, and delivers each OFDM symbol as 48 groups of N_BPSC bits, one group per accepted cycle. Ping-pong storage lets one symbol fill while the previous drains.

## Interface
- No parameters. N_CBPS/N_BPSC are derived from `mod`: 0=BPSK (48/1), 1=QPSK (96/2), 2=16QAM (192/4), 3=64QAM (288/6).
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mod  in  2  modulation code, encoding above
- in_bit  in  1  coded bit k of the current symbol
- in_valid  in  1  in_bit is presented
- in_ready  out  1  write bank can accept a bit
- out_bits  out  6  one subcarrier group; out_bits[b] = interleaved bit j = 48·0+m·N_BPSC+b, upper unused bits 0
- out_valid  out  1  a full symbol is available in the read bank
- out_ready  in  1  mapper accepts out_bits this cycle

## Operation
- Storage: two 288-bit banks A/B, each with a full flag. Write pointer wbank and read pointer rbank start at A.
- Input accept = in_valid && in_ready; in_ready = ~full[wbank].
- Write counters: r (k mod 16, 0..15), q (k/16, 0..N_COL−1), N_COL = N_CBPS/16 = 3/6/12/18. Advance r; on r wrap, advance q.
- Write address j per accepted bit: i = N_COL·r + q.
  - BPSK/QPSK (s=1): j = i.
  - 16QAM (s=2): j = i − (q mod 2) + ((q − r) mod 2).
  - 64QAM (s=3): j = i − (q mod 3) + ((q − r) mod 3); keep a q-mod-3 counter, no dividers.
  - Mod results are non-negative (0..s−1).
- Bank mod latched when k=0 is accepted; mod changes mid-symbol ignored for that bank. Read side uses the bank's latched mod.
- Accept of bit k=N_CBPS−1: set full[wbank], toggle wbank, clear r/q.
- Read: out_valid = full[rbank]. Subcarrier counter m (0..47). out_bits[b] = bank[rbank][m·N_BPSC+b] for b<N_BPSC, else 0.
- Output accept = out_valid && out_ready: m++. Accept at m=47: clear full[rbank], toggle rbank, m=0.
- Symbol length in output groups is always 48 for every mod.

## Timing
- Reset: in_ready=1, out_valid=0, out_bits=0, both banks and flags cleared, wbank=rbank=A, all counters 0.
- Reset mid-symbol discards all partial and full symbols. No output follows until a new complete symbol arrives.
- Latency: last bit accepted at edge T → out_valid=1 in the cycle after T, with group m=0 presented.
- Throughput: 1 bit/cycle in; 1 group/cycle out with out_ready held high. No bubbles between back-to-back symbols when both banks cycle.
- out_bits/out_valid are driven from registers and the bank, with no combinational path from in_* inputs. in_ready is driven from registered flags only.
- Same edge, writer completes bank X and reader releases bank Y: both flag updates take effect.
- Reader releases the bank the writer is stalled on: in_ready=1 in the next cycle.
- Both banks full: in_ready=0; in_bit ignored while in_ready=0.
- out_valid=1 with out_ready=0: out_bits and m hold.

## Test plan
- BPSK, 48 bits with only k=1 set, out_ready=1 → exactly group m=3 has out_bits=6'b000001; all others 0; out_valid high 48 cycles starting the cycle after the last input.
- QPSK, only k=16 set → m=0 has out_bits=6'b000010, others 0.
- 16QAM, only k=17 set → m=3 has out_bits[0]=1, others 0.
- 64QAM, only k=1 set → m=3 has out_bits=6'b000100.
- BPSK, out_ready=0, stream 97 bits → in_ready drops after bit 96 is accepted; bit 97 waits. Raise out_ready → after 48 groups, in_ready=1 next cycle; the symbols drain in order.
- Assert rst at k=20 of a QPSK symbol, then send a new BPSK symbol → no output before the new symbol completes; output matches the BPSK reference; mod change mid-symbol has no effect on the permutation.
